// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW into data-memory byte lanes, queues them and drains via req/ack.
// Optional macro STBUF_MERGE_EN coalesces same-word stores into the youngest non-head entry.
`ifndef ALUOP_BUS
`define ALUOP_BUS 7:0
`endif
`ifndef REG_BUS
`define REG_BUS 31:0
`endif
`ifndef DATA_WE_BUS
`define DATA_WE_BUS 3:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef MINIMIPS32_SB
`define MINIMIPS32_SB 8'h98
`endif
`ifndef MINIMIPS32_SH
`define MINIMIPS32_SH 8'h99
`endif
`ifndef MINIMIPS32_SW
`define MINIMIPS32_SW 8'h9A
`endif

module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,
    input  logic                st_req_i,
    input  logic [`ALUOP_BUS]   st_aluop_i,
    input  logic [31:0]         st_addr_i,
    input  logic [`REG_BUS]     st_data_i,
    output logic                st_stall_o,
    output logic                st_misalign_o,
    input  logic                ld_req_i,
    input  logic [31:0]         ld_addr_i,
    output logic                ld_hazard_o,
    output logic                dm_req_o,
    input  logic                dm_ack_i,
    output logic [31:0]         dm_addr_o,
    output logic [`DATA_WE_BUS] dm_we_o,
    output logic [`DATA_BUS]    dm_din_o,
    output logic                empty_o
);
    localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [3:0]       we_q   [DEPTH];
    logic [31:0]      din_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             misalign_q;

    logic        is_sb, is_sh, is_sw, legal, misalign;
    logic [3:0]  fmt_we;
    logic [31:0] fmt_din;
    logic        full, empty, mergeable, accept, push, deq, hit;
    logic        unused_ld_lo;

    assign unused_ld_lo = ^ld_addr_i[1:0];

    assign is_sb    = (st_aluop_i == `MINIMIPS32_SB);
    assign is_sh    = (st_aluop_i == `MINIMIPS32_SH);
    assign is_sw    = (st_aluop_i == `MINIMIPS32_SW);
    assign legal    = is_sb | is_sh | is_sw;
    assign misalign = (is_sh & st_addr_i[0]) | (is_sw & (st_addr_i[1:0] != 2'b00));

    // Lane 3 (bits 31:24) is the lowest byte address, matching the load extraction order.
    always_comb begin
        fmt_we  = 4'b0000;
        fmt_din = 32'h0;
        if (is_sw) begin
            fmt_we  = 4'b1111;
            fmt_din = {st_data_i[7:0], st_data_i[15:8], st_data_i[23:16], st_data_i[31:24]};
        end else if (is_sh) begin
            fmt_we  = st_addr_i[1] ? 4'b0011 : 4'b1100;
            fmt_din = {2{st_data_i[7:0], st_data_i[15:8]}};
        end else if (is_sb) begin
            case (st_addr_i[1:0])
                2'd0:    fmt_we = 4'b1000;
                2'd1:    fmt_we = 4'b0100;
                2'd2:    fmt_we = 4'b0010;
                default: fmt_we = 4'b0001;
            endcase
            fmt_din = {4{st_data_i[7:0]}};
        end
    end

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);

`ifdef STBUF_MERGE_EN
    logic [PTR_W-1:0] last_idx;
    logic [31:0]      merge_din;

    assign last_idx  = tail_q - PTR_W'(1);
    // count>=2 keeps the merge target away from the head that may be in flight to memory.
    assign mergeable = st_req_i && legal && !misalign && (count_q >= (PTR_W + 1)'(2)) &&
                       (addr_q[last_idx] == st_addr_i[31:2]);

    always_comb begin
        merge_din = din_q[last_idx];
        for (int i = 0; i < 4; i++) begin
            if (fmt_we[i]) merge_din[8*i +: 8] = fmt_din[8*i +: 8];
        end
    end
`else
    assign mergeable = 1'b0;
`endif

    assign accept = st_req_i && legal && !misalign && (!full || mergeable);
    assign push   = accept && !mergeable;
    assign deq    = !empty && dm_ack_i;

    assign st_stall_o    = st_req_i && full && !misalign && !mergeable;
    assign st_misalign_o = misalign_q;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr_i[31:2])) hit = 1'b1;
        end
        if (accept && (st_addr_i[31:2] == ld_addr_i[31:2])) hit = 1'b1;
    end

    assign ld_hazard_o = ld_req_i && hit;

    assign empty_o   = empty;
    assign dm_req_o  = !empty;
    assign dm_addr_o = empty ? 32'h0 : {addr_q[head_q], 2'b00};
    assign dm_we_o   = empty ? 4'h0 : we_q[head_q];
    assign dm_din_o  = empty ? 32'h0 : din_q[head_q];

    always_comb begin
        count_d = count_q;
        if (push && !deq) begin
            count_d = count_q + 1'b1;
        end else if (!push && deq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= st_req_i && misalign;
            count_q    <= count_d;
            if (deq) begin
                head_q          <= head_q + 1'b1;
                valid_q[head_q] <= 1'b0;
            end
            if (push) begin
                tail_q          <= tail_q + 1'b1;
                valid_q[tail_q] <= 1'b1;
            end
        end
    end

    // Payload needs no reset: valid_q and count_q gate every use of it.
    always_ff @(posedge cpu_clk_50M) begin
        if (push) begin
            addr_q[tail_q] <= st_addr_i[31:2];
            we_q[tail_q]   <= fmt_we;
            din_q[tail_q]  <= fmt_din;
        end
`ifdef STBUF_MERGE_EN
        else if (accept) begin
            we_q[last_idx]  <= we_q[last_idx] | fmt_we;
            din_q[last_idx] <= merge_din;
        end
`endif
    end

endmodule
